// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-period math and line levels.
// Used by both the transmit serializer and the receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int   BIT_IDX_W   = 3;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Width of a counter that must hold 0..div-1.
    function automatic int cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: o_tick marks the last clock of every DIV-clock period.
// restart holds the count at zero so the next period starts phase-aligned.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic o_tick
);

    localparam int            CNT_W = cnt_width(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || o_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_tick = !restart && (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-to-serial UART transmitter with a one-entry holding register, 8 data bits LSB first.
// Define UART_TX_PARITY_EN to insert a parity bit (sense chosen by PARITY_ODD).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 10000000,
    parameter int BAUD       = 9600,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done,
    output uart_state_e dbg_state
);

    // Handshake: a byte is taken on any rising edge where i_valid && o_ready;
    // o_ready is simply "holding register empty" and never looks at i_valid.

    localparam int   DIV       = calc_div(CLK_FREQ, BAUD);
    localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    uart_state_e          state, next_state;
    logic [7:0]           hold_data, data_q;
    logic                 hold_full;
    logic [BIT_IDX_W-1:0] bit_idx, next_bit_idx;
    logic                 stop_idx;
    logic                 tx_q, tx_d;
    logic                 tick, load, baud_restart, last_stop;

    assign baud_restart = (state == ST_IDLE);
    assign last_stop    = (stop_idx == LAST_STOP);

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (baud_restart),
        .o_tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hold_full) begin
                    next_state = ST_START;
                    load       = 1'b1;
                end
            end
            ST_START: if (tick) next_state = ST_DATA;
            ST_DATA: begin
                if (tick && bit_idx == BIT_IDX_W'(7)) begin
`ifdef UART_TX_PARITY_EN
                    next_state = ST_PARITY;
`else
                    next_state = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (tick) next_state = ST_STOP;
`endif
            ST_STOP: begin
                // A queued byte starts its frame on the very next edge: no idle gap.
                if (tick && last_stop) begin
                    if (hold_full) begin
                        next_state = ST_START;
                        load       = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Line level is computed for the state being entered so o_tx is a clean flop.
    always_comb begin
        next_bit_idx = (state == ST_DATA && tick) ? bit_idx + 1'b1 : bit_idx;
        tx_d         = IDLE_LEVEL;
        case (next_state)
            ST_START:  tx_d = START_LEVEL;
            ST_DATA:   tx_d = data_q[next_bit_idx];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = (^data_q) ^ (PARITY_ODD != 0);
`endif
            default:   tx_d = IDLE_LEVEL;
        endcase
        o_busy = (state != ST_IDLE);
        o_done = (state == ST_STOP) && tick && last_stop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            data_q    <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            tx_q      <= IDLE_LEVEL;
        end else begin
            // Load is evaluated before the write so a same-edge refill keeps hold_full set.
            if (load) begin
                data_q    <= hold_data;
                hold_full <= 1'b0;
                bit_idx   <= '0;
            end else begin
                bit_idx   <= next_bit_idx;
            end
            if (i_valid && o_ready) begin
                hold_data <= i_data;
                hold_full <= 1'b1;
            end
            if (state == ST_STOP && tick) begin
                stop_idx <= last_stop ? 1'b0 : 1'b1;
            end
            tx_q <= tx_d;
        end
    end

    assign o_ready   = !hold_full;
    assign o_tx      = tx_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer at DIV=16: unit 0 is 8N1/even, unit 1 is 8N2/odd.
// A line monitor decodes every frame and compares it against an expected-byte queue.
module tb_uart_tx_serializer;
    import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FA = 16 * (10 + PAR);
    localparam int FB = 16 * (11 + PAR);

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data [2];
    logic [1:0] valid;
    logic       ready0, ready1, tx0, tx1, busy0, busy1, done0, done1;
    logic [1:0] ready, tx, busy, done;
    uart_state_e st0, st1;

    assign ready = {ready1, ready0};
    assign tx    = {tx1, tx0};
    assign busy  = {busy1, busy0};
    assign done  = {done1, done0};

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLK_FREQ(16), .BAUD(1), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_data(data[0]), .i_valid(valid[0]), .o_ready(ready0),
        .o_tx(tx0), .o_busy(busy0), .o_done(done0), .dbg_state(st0)
    );

    uart_tx_serializer #(.CLK_FREQ(16), .BAUD(1), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_data(data[1]), .i_valid(valid[1]), .o_ready(ready1),
        .o_tx(tx1), .o_busy(busy1), .o_done(done1), .dbg_state(st1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    bit          m_act [2];
    int          m_cnt [2];
    logic [15:0] m_bits [2];
    int          rx_cnt [2];
    int          dcnt [2];
    int          bcnt [2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic par_of(input int u, input logic [7:0] b);
        return (^b) ^ (u == 1);
    endfunction

    // Line monitor: samples mid-bit, decodes the frame, checks it against the queue.
    task automatic monitor(input int u);
        int         frame = (u == 0) ? FA : FB;
        int         nb    = frame / 16;
        logic [7:0] b;
        logic [7:0] e;
        logic       stop_ok;
        if (!rst_n) begin
            m_act[u] = 1'b0;
            return;
        end
        if (done[u]) dcnt[u]++;
        if (busy[u]) bcnt[u]++;
        if (!m_act[u] && tx[u] == 1'b0) begin
            m_act[u] = 1'b1;
            m_cnt[u] = 0;
        end
        if (m_act[u]) begin
            if (done[u]) check($sformatf("done_timing_%0d", u), 32'(m_cnt[u]), 32'(frame - 1));
            if (m_cnt[u] % 16 == 8) m_bits[u][m_cnt[u] / 16] = tx[u];
            if (m_cnt[u] == frame - 1) begin
                b = m_bits[u][8:1];
                check($sformatf("start_bit_%0d", u), 32'(m_bits[u][0]), 32'(0));
`ifdef UART_TX_PARITY_EN
                check($sformatf("parity_bit_%0d", u), 32'(m_bits[u][9]), 32'(par_of(u, b)));
`endif
                stop_ok = 1'b1;
                for (int k = 9 + PAR; k < nb; k++) stop_ok &= m_bits[u][k];
                check($sformatf("stop_bits_%0d", u), 32'(stop_ok), 32'(1));
                rx_cnt[u]++;
                if ((u == 0 && exp_q0.size() == 0) || (u == 1 && exp_q1.size() == 0)) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame_%0d: got 0x%0h expected no frame", u, b);
                end else begin
                    e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check($sformatf("rx_byte_%0d", u), 32'(b), 32'(e));
                end
                m_act[u] = 1'b0;
            end else begin
                m_cnt[u]++;
            end
        end
    endtask

    always @(negedge clk) begin
        monitor(0);
        monitor(1);
    end

    // Returns #1 after the acceptance edge.
    task automatic send(input int u, input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        data[u]  = b;
        valid[u] = 1'b1;
        while (!ready[u] && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("accept_ready", 32'(ready[u]), 32'(1));
        if (u == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
        @(posedge clk);
        #1;
        valid[u] = 1'b0;
    endtask

    task automatic wait_done(input int u);
        int t = 0;
        while (t < 1000) begin
            @(negedge clk);
            if (done[u]) break;
            t++;
        end
        check("done_seen", 32'(done[u]), 32'(1));
    endtask

    task automatic wait_idle(input int u);
        int t = 0;
        while (t < 3000) begin
            @(negedge clk);
            if (!busy[u] && ready[u] && ((u == 0) ? exp_q0.size() == 0 : exp_q1.size() == 0)) break;
            t++;
        end
        check("drained_busy", 32'(busy[u]), 32'(0));
    endtask

    typedef struct {
        logic [7:0] data;
        logic [8:0] line;   // bit i = level in bit period i: start, then d0..d7
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, d0, r0, low, exp_low;
        vecs[0] = '{8'h41, 9'b010000010};
        vecs[1] = '{8'h00, 9'b000000000};
        vecs[2] = '{8'hFF, 9'b111111110};
        vecs[3] = '{8'hA5, 9'b101001010};
        vecs[4] = '{8'h07, 9'b000001110};
        vecs[5] = '{8'h3C, 9'b001111000};

        rst_n = 1'b0;
        valid = 2'b00;
        data[0] = 8'h00;
        data[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'(2'b11));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_ready", 32'(ready), 32'(2'b11));
        check("rst_state", 32'(st0), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single frames from idle, bit-by-bit against the table.
        for (int v = 0; v < 6; v++) begin
            b0 = bcnt[0];
            send(0, vecs[v].data);
            check("ready_after_accept", 32'(ready[0]), 32'(0));
            @(posedge clk);
            #1;
            check("start_tx", 32'(tx[0]), 32'(0));
            check("start_busy", 32'(busy[0]), 32'(1));
            check("ready_after_load", 32'(ready[0]), 32'(1));
            for (int i = 0; i < 9; i++) begin
                repeat ((i == 0) ? 8 : 16) @(posedge clk);
                #1;
                check($sformatf("line_bit%0d_v%0d", i, v), 32'(tx[0]), 32'(vecs[v].line[i]));
            end
            repeat (FA - 1 - 136) @(posedge clk);
            #1;
            check("done_last_cycle", 32'(done[0]), 32'(1));
            @(posedge clk);
            #1;
            check("idle_busy", 32'(busy[0]), 32'(0));
            check("idle_tx", 32'(tx[0]), 32'(1));
            check("busy_cycles", 32'(bcnt[0] - b0), 32'(FA));
            wait_idle(0);
        end

        // Back-to-back: second frame starts on the edge after the first done.
        b0 = bcnt[0];
        d0 = dcnt[0];
        send(0, 8'h55);
        send(0, 8'hAA);
        check("b2b_ready_low", 32'(ready[0]), 32'(0));
        wait_done(0);
        @(posedge clk);
        #1;
        check("b2b_restart_tx", 32'(tx[0]), 32'(0));
        check("b2b_busy", 32'(busy[0]), 32'(1));
        wait_idle(0);
        check("b2b_busy_cycles", 32'(bcnt[0] - b0), 32'(2 * FA));
        check("b2b_done_pulses", 32'(dcnt[0] - d0), 32'(2));

        // Backpressure: third byte only accepted after the first frame finished.
        d0 = dcnt[0];
        r0 = rx_cnt[0];
        send(0, 8'h12);
        send(0, 8'h34);
        send(0, 8'h56);
        check("bp_third_after_first", 32'(dcnt[0] - d0), 32'(1));
        check("bp_ready_low", 32'(ready[0]), 32'(0));
        wait_idle(0);
        check("bp_frame_count", 32'(rx_cnt[0] - r0), 32'(3));

        // Reset mid-frame discards both the frame and the queued byte.
        send(0, 8'h0F);
        send(0, 8'h99);
        repeat (69) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx[0]), 32'(1));
        check("mid_rst_ready", 32'(ready[0]), 32'(1));
        check("mid_rst_busy", 32'(busy[0]), 32'(0));
        exp_q0.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        r0 = rx_cnt[0];
        send(0, 8'h33);
        wait_idle(0);
        check("post_rst_frames", 32'(rx_cnt[0] - r0), 32'(1));

        // Two stop bits: count low cycles, then the queued frame starts exactly at FB.
        exp_low = 144 + ((PAR == 1 && par_of(1, 8'h00) == 1'b0) ? 16 : 0);
        low = 0;
        send(1, 8'h00);
        for (int c = 0; c < FB; c++) begin
            @(posedge clk);
            #1;
            if (tx[1] == 1'b0) low++;
            if (c == 100) begin
                data[1]  = 8'hC3;
                valid[1] = 1'b1;
                exp_q1.push_back(8'hC3);
            end
            if (c == 101) valid[1] = 1'b0;
            if (c == FB - 1) check("stop2_done", 32'(done[1]), 32'(1));
        end
        check("stop2_low_cycles", 32'(low), 32'(exp_low));
        @(posedge clk);
        #1;
        check("stop2_next_start", 32'(tx[1]), 32'(0));
        wait_idle(1);
        check("stop2_frames", 32'(rx_cnt[1]), 32'(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
